// File: rtl/int_seq.sv
// int_seq: interrupt entry/return sequencer between the interrupt
// controller and the fetch/retire pipeline, with take counter and watchdog.
module int_seq #(
  parameter int ISR_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq,
  input  logic [31:0]      EAddr,
  input  logic [31:0]      pc_next,
  input  logic             retire,
  input  logic             eret,
  input  logic             ie_we,
  input  logic             ie_wd,
  output logic             iack,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [31:0]      epc,
  output logic             in_isr,
  output logic             ie,
  output logic [CNT_W-1:0] irq_count,
  output logic             isr_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    ISR,
    RET
  } state_e;

  localparam int WD_W = $clog2(ISR_TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(ISR_TIMEOUT);

  state_e           state_q, state_d;
  logic             ie_q, to_q, to_d;
  logic [31:0]      epc_q, rpc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             take, ret;

  // take decision uses the pre-write ie value
  assign take = (state_q == IDLE) && irq && ie_q && retire;
  assign ret  = (state_q == ISR) && retire && eret;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (take) state_d = ENTER;
      ENTER: state_d = ISR;
      ISR:   if (ret) state_d = RET;
      RET:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iack     = 1'b0;
    redirect = 1'b0;
    in_isr   = 1'b0;
    unique case (state_q)
      IDLE: ;
      ENTER: begin
        iack     = 1'b1;
        redirect = 1'b1;
      end
      ISR: in_isr = 1'b1;
      RET: begin
        redirect = 1'b1;
        in_isr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign flush = redirect;

  // watchdog saturates at the limit; a zero limit never fires
  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (state_q == ENTER) begin
      wd_d = '0;
    end else if (state_q == ISR) begin
      if (wd_q != WD_LIM) wd_d = wd_q + WD_W'(1);
      if (ISR_TIMEOUT != 0 && wd_d == WD_LIM) to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q  <= 1'b0;
      epc_q <= '0;
      rpc_q <= '0;
      cnt_q <= '0;
      wd_q  <= '0;
      to_q  <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
      if (ie_we) ie_q <= ie_wd;
      if (take) begin
        epc_q <= pc_next;
        rpc_q <= {EAddr[31:2], 2'b00};
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (ret) rpc_q <= epc_q;
    end
  end

  assign redirect_pc = rpc_q;
  assign epc         = epc_q;
  assign ie          = ie_q;
  assign irq_count   = cnt_q;
  assign isr_timeout = to_q;

endmodule

// File: tb/tb_int_seq.sv
// tb_int_seq: directed and random stimulus for int_seq, checked every
// cycle by a queue-based scoreboard fed from a reference model.
module tb_int_seq;

  localparam int T  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, irq, retire, eret, ie_we, ie_wd;
  logic [31:0]   EAddr, pc_next;
  logic          iack, redirect, flush, in_isr, ie, isr_timeout;
  logic [31:0]   redirect_pc, epc;
  logic [CW-1:0] irq_count;

  int_seq #(.ISR_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .irq(irq), .EAddr(EAddr),
    .pc_next(pc_next), .retire(retire), .eret(eret),
    .ie_we(ie_we), .ie_wd(ie_wd), .iack(iack),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .epc(epc), .in_isr(in_isr), .ie(ie),
    .irq_count(irq_count), .isr_timeout(isr_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          iack;
    logic          redirect;
    logic          flush;
    logic          in_isr;
    logic          ie;
    logic          to;
    logic [CW-1:0] cnt;
    logic [31:0]   rpc;
    logic [31:0]   epc;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  // reference model: what the handler is doing and what has been saved
  bit          m_entering, m_handling, m_returning;
  bit          m_ie, m_to;
  int          m_cnt, m_isr_cycles;
  logic [31:0] m_epc, m_rpc;

  task automatic model(input logic r, i, input logic [31:0] ea, pc,
                       input logic rt, er, we, wd);
    bit busy, take, leave;
    obs_t e;
    if (r) begin
      m_entering = 0; m_handling = 0; m_returning = 0;
      m_ie = 0; m_to = 0; m_cnt = 0; m_isr_cycles = 0;
      m_epc = 0; m_rpc = 0;
    end else begin
      busy  = m_entering || m_handling || m_returning;
      take  = !busy && i && m_ie && rt;
      leave = m_handling && rt && er;
      if (m_entering) m_isr_cycles = 0;
      if (m_handling) begin
        if (m_isr_cycles < T) m_isr_cycles++;
        if (T != 0 && m_isr_cycles == T) m_to = 1;
      end
      if (take) begin
        m_epc = pc;
        m_rpc = ea & 32'hFFFF_FFFC;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      if (leave) m_rpc = m_epc;
      if (we) m_ie = wd;
      m_handling  = m_entering || (m_handling && !leave);
      m_returning = leave;
      m_entering  = take;
    end
    e.iack     = m_entering;
    e.redirect = m_entering || m_returning;
    e.flush    = m_entering || m_returning;
    e.in_isr   = m_handling || m_returning;
    e.ie       = m_ie;
    e.to       = m_to;
    e.cnt      = CW'(m_cnt);
    e.rpc      = m_rpc;
    e.epc      = m_epc;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, i, input logic [31:0] ea, pc,
                     input logic rt, er, we, wd);
    rst = r; irq = i; EAddr = ea; pc_next = pc;
    retire = rt; eret = er; ie_we = we; ie_wd = wd;
    model(r, i, ea, pc, rt, er, we, wd);
    @(posedge clk);
    #2;
  endtask

  // monitor: compares every presented output bundle against the queue head
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (!done) begin
          checks++; errors++;
          $display("FAIL underflow: no expected entry at %0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        a = '{iack, redirect, flush, in_isr, ie, isr_timeout,
              irq_count, redirect_pc, epc};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got %h expected %h", $time, a, e);
        end
      end
    end
  end

  initial begin
    int ph;
    logic [31:0] ea, pc;
    // reset, then enable
    cyc(1,0,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,1,1);
    // basic take and return
    cyc(0,1,32'h180,32'h44,1,0,0,0);
    cyc(0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0);
    cyc(0,0,0,0,1,1,0,0);
    cyc(0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // boundary wait, then take with misaligned vector
    repeat (5) cyc(0,1,32'h300,32'h10,0,0,0,0);
    cyc(0,1,32'h203,32'h88,1,0,0,0);
    repeat (3) cyc(0,1,0,0,0,0,0,0);
    cyc(0,1,0,0,1,1,0,0);
    cyc(0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // masked: ie=0 never takes; spurious eret in idle
    cyc(0,0,0,0,0,0,1,0);
    repeat (6) cyc(0,1,32'h400,32'h20,1,1,0,0);
    // enable written in the take cycle only takes afterwards
    cyc(0,1,32'h500,32'h30,1,0,1,1);
    cyc(0,1,32'h504,32'h34,1,0,0,0);
    repeat (3) cyc(0,1,0,0,1,1,0,0);
    // back-to-back with everything held high
    repeat (12) cyc(0,1,32'h600,32'h60,1,1,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // watchdog: long ISR
    cyc(0,1,32'h700,32'h70,1,0,0,0);
    repeat (11) cyc(0,1,0,0,1,0,0,0);
    cyc(0,0,0,0,1,1,0,0);
    repeat (3) cyc(0,0,0,0,0,0,0,0);
    // reset during ENTER, then during ISR
    cyc(0,0,0,0,0,0,1,1);
    cyc(0,1,32'h800,32'h80,1,0,0,0);
    cyc(1,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,1,1);
    cyc(0,1,32'h900,32'h90,1,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // random traffic; eret probability varies by phase
    ph = 30;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) ph = $urandom_range(2, 60);
      ea = $urandom;
      pc = $urandom;
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 99) < 60, ea, pc,
          $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < ph,
          $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 85);
    end
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_seq.md
# int_seq

CPU-side interrupt entry/return sequencer that sits directly downstream of the interrupt controller. It consumes the controller's `irq` and 32-bit vector `EAddr` and waits for an instruction boundary. It then saves the return PC, redirects fetch to the vector, flushes the pipeline and pulses `iack` back to the controller. On a retired `eret` it restores the saved PC. Nesting is not supported. The block also keeps a taken-interrupt counter and an ISR-timeout watchdog.

## Interface
- `ISR_TIMEOUT`, 1024: cycles allowed in ISR state before `isr_timeout` sets; 0 disables the watchdog.
- `CNT_W`, 16: width of `irq_count`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `irq`  in  1  level interrupt request from the controller.
- `EAddr`  in  32  handler vector from the controller; sampled only on the take cycle.
- `pc_next`  in  32  address of the next sequential instruction after the one retiring this cycle.
- `retire`  in  1  an instruction retires this cycle (the only legal boundary).
- `eret`  in  1  the retiring instruction is a return-from-interrupt; meaningful only with `retire`.
- `ie_we`  in  1  write strobe for the global interrupt-enable bit.
- `ie_wd`  in  1  new interrupt-enable value.
- `iack`  out  1  one-cycle acknowledge pulse to the controller.
- `redirect`  out  1  fetch must load `redirect_pc` this cycle.
- `redirect_pc`  out  32  redirect target.
- `flush`  out  1  kill all younger in-flight instructions; asserted with `redirect`.
- `epc`  out  32  saved return address.
- `in_isr`  out  1  handler is executing.
- `ie`  out  1  current global interrupt enable.
- `irq_count`  out  CNT_W  count of interrupts taken, saturating.
- `isr_timeout`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ENTER, ISR, RET. Reset state is IDLE.
- Reset values:
  - `iack`, `redirect`, `flush`, `in_isr`, `isr_timeout` = 0.
  - `redirect_pc`, `epc`, `irq_count` = 0.
  - `ie` = 0.
- **IDLE.** The take condition is `irq && ie && retire`.
  - On take: `epc <= pc_next`, `vec <= {EAddr[31:2],2'b00}` (low bits forced to zero), go to ENTER.
  - `irq` without `retire` waits indefinitely; nothing is sampled.
- **ENTER** (exactly 1 cycle):
  - `redirect=1`, `flush=1`, `redirect_pc=vec`, `iack=1`.
  - `irq_count` increments, saturating at all-ones.
  - Watchdog counter clears. Next state is ISR.
- **ISR:**
  - `in_isr=1`. `irq` is ignored (no nesting).
  - The watchdog counter increments each cycle. When it reaches `ISR_TIMEOUT`, set `isr_timeout`; it stays set until reset. The counter holds at the limit.
  - `retire && eret` goes to RET.
- **RET** (exactly 1 cycle):
  - `redirect=1`, `flush=1`, `redirect_pc=epc`, `in_isr=1`.
  - Next state is IDLE.
- **`ie` register:**
  - `ie_we` writes `ie_wd` in any state.
  - The take decision uses the pre-write `ie` value, so a write in the same cycle affects the next cycle only.
- **`eret` outside ISR:** ignored; no redirect.
- **`redirect_pc` when `redirect=0`:** holds its last value.

## Timing
- Take latency: take cycle N, then `redirect`/`flush`/`iack` high in cycle N+1.
- Earliest fetch of the handler is N+2.
- The controller sees `iack` at N+1 and may drop `irq` from N+2. The sequencer does not look at `irq` again until it is back in IDLE.
- Return latency: `eret` retires in cycle M, `redirect` to `epc` in M+1, state is IDLE in M+2.
  - An `irq` still pending at M+2 can be taken on the first `retire` at or after M+2.
  - Minimum spacing between two ENTER pulses is therefore 4 cycles.
- `iack` is never high for more than one consecutive cycle. It is never high outside ENTER.
- `redirect` and `flush` are always asserted together.
- Reset asserted in any state (including ENTER or RET) returns to IDLE on the next edge with reset values.
  - No `iack` or `redirect` is emitted in the cycle after reset.

## Test plan
- **Basic take/return.**
  - Stimulus: `ie=1`; `irq=1`, `EAddr=0x0000_0180`, `retire=1`, `pc_next=0x0000_0044`.
  - Next cycle: `iack=1`, `redirect=1`, `flush=1`, `redirect_pc=0x180`, `epc=0x44`, `irq_count=1`.
  - Later `retire&eret`: next cycle `redirect_pc=0x44`; IDLE one cycle after.
- **Boundary wait and masking.**
  - `irq=1`, `ie=1`, `retire=0` for 5 cycles: no `iack`.
  - `retire=1`: take.
  - Repeat with `ie=0`: no take ever.
  - `ie_we=1`, `ie_wd=1` in the same cycle as `irq&retire`: no take that cycle, take on the next `retire`.
- **No nesting / back-to-back.** `irq` held high throughout ISR.
  - No second `iack` until after RET.
  - Second ENTER exactly 4 cycles after the first if `retire` is continuously high.
- **Vector alignment and spurious eret.**
  - `EAddr=0x0000_0203` yields `redirect_pc=0x200`.
  - `eret&retire` in IDLE produces no redirect.
- **Watchdog and saturation.**
  - With `ISR_TIMEOUT=8`, stay in ISR 8 cycles: `isr_timeout=1` and it remains after `eret`.
  - With `CNT_W=2`: after 5 takes, `irq_count=3`.
- **Reset mid-operation.**
  - Assert `rst` during ENTER and during ISR: the next cycle gives IDLE, all outputs 0, `ie=0`, `epc=0`.
